decode_stage: RTL and testbench

Registered, parametrised successor to the combinational instruction decoder; sits between fetch and execute. Accepts instructions with a PC tag over a valid/ready handshake and decodes them into a packed control bundle. Results are buffered in a DEPTH-entry in-order queue. Adds illegal-opcode detection, pipeline flush and a saturating illegal-instruction counter.

---
 rtl/decoder_pkg.sv | 119 +++++++++++
 rtl/decode_fifo.sv | 82 ++++++++
 rtl/decode_stage.sv | 78 +++++++
 tb/tb_decode_stage.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Decoder types, field encodings and the pure decode function shared by the decode stage.
// Field map is fixed for a 16-bit instruction word; callers pass bits [15:0].
package decoder_pkg;

  localparam int ADDR_IMM_W = 12;
  localparam int DATA_IMM_W = 8;

  localparam logic [2:0] OP_ALU_IMM = 3'b000;
  localparam logic [2:0] OP_ALU_REG = 3'b001;
  localparam logic [2:0] OP_MISC    = 3'b010;
  localparam logic [2:0] OP_JMPI    = 3'b100;
  localparam logic [2:0] OP_JMP     = 3'b111;

  localparam logic [3:0] FN_LOAD  = 4'd0;
  localparam logic [3:0] FN_STORE = 4'd1;
  localparam logic [3:0] FN_GET   = 4'd2;
  localparam logic [3:0] FN_PUT   = 4'd3;
  localparam logic [3:0] FN_SET   = 4'd4;
  localparam logic [3:0] FN_JMPR  = 4'd0;
  localparam logic [3:0] FN_JMP   = 4'd1;

  typedef struct packed {
    logic                  jump_branch_select;
    logic                  immediate_address_select;
    logic                  unconditional_branch;
    logic                  jump_relative;
    logic [2:0]            branch_condition;
    logic [ADDR_IMM_W-1:0] address_immediate;
    logic [2:0]            alu_function;
    logic                  alu_output_enable;
    logic                  status_write_enable;
    logic [DATA_IMM_W-1:0] alu_operand_b_immediate;
    logic                  acc_write_enable;
    logic [DATA_IMM_W-1:0] acc_immediate;
    logic                  read_data_output_enable;
    logic [3:0]            reg_addr;
    logic                  read_get_acc;
    logic                  write_put_acc;
    logic                  data_memory_output_enable;
    logic                  data_memory_write_enable;
  } decoded_ctrl_t;

  typedef struct packed {
    decoded_ctrl_t ctrl;
    logic          illegal;
  } decode_result_t;

  // Illegal encodings leave the whole bundle zero so nothing downstream fires.
  function automatic decode_result_t decode_inst(input logic [15:0] instr);
    decode_result_t r;
    logic [2:0]     op;
    logic [3:0]     fn;
    r  = '0;
    op = instr[3:1];
    fn = instr[7:4];
    if (instr[0]) begin
      r.ctrl.jump_branch_select       = 1'b1;
      r.ctrl.immediate_address_select = 1'b1;
      r.ctrl.branch_condition         = instr[3:1];
      r.ctrl.address_immediate        = instr[15:4];
    end else begin
      case (op)
        OP_ALU_IMM, OP_ALU_REG: begin
          r.ctrl.alu_function        = fn[2:0];
          r.ctrl.alu_output_enable   = 1'b1;
          r.ctrl.acc_write_enable    = 1'b1;
          r.ctrl.status_write_enable = 1'b1;
          if (op == OP_ALU_IMM) begin
            r.ctrl.alu_operand_b_immediate = instr[15:8];
          end else begin
            r.ctrl.read_data_output_enable = 1'b1;
            r.ctrl.reg_addr                = instr[11:8];
          end
        end
        OP_MISC: begin
          case (fn)
            FN_LOAD: begin
              r.ctrl.data_memory_output_enable = 1'b1;
              r.ctrl.acc_write_enable          = 1'b1;
            end
            FN_STORE: r.ctrl.data_memory_write_enable = 1'b1;
            FN_GET: begin
              r.ctrl.read_get_acc     = 1'b1;
              r.ctrl.acc_write_enable = 1'b1;
              r.ctrl.reg_addr         = instr[11:8];
            end
            FN_PUT: begin
              r.ctrl.write_put_acc = 1'b1;
              r.ctrl.reg_addr      = instr[11:8];
            end
            FN_SET: begin
              r.ctrl.acc_write_enable = 1'b1;
              r.ctrl.acc_immediate    = instr[15:8];
            end
            default: r.illegal = 1'b1;
          endcase
        end
        OP_JMPI: begin
          r.ctrl.jump_branch_select       = 1'b1;
          r.ctrl.immediate_address_select = 1'b1;
          r.ctrl.unconditional_branch     = 1'b1;
          r.ctrl.address_immediate        = instr[15:4];
        end
        OP_JMP: begin
          if (fn == FN_JMPR || fn == FN_JMP) begin
            r.ctrl.jump_branch_select   = 1'b1;
            r.ctrl.unconditional_branch = 1'b1;
            r.ctrl.jump_relative        = (fn == FN_JMPR);
          end else begin
            r.illegal = 1'b1;
          end
        end
        default: r.illegal = 1'b1;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic in-order sync FIFO with flush; write visible at the output one cycle after push.
// push_rdy/pop_vld are registered; a full FIFO refuses pushes even while popping.
module decode_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             vld_q;
  logic             rdy_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push   = push_vld & rdy_q & ~flush;
    do_pop    = pop_rdy & vld_q;
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_q  <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_q  <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
      vld_q <= (count_nxt != '0);
      rdy_q <= (count_nxt != FULL_CNT);
    end
  end

  assign push_rdy = rdy_q;
  assign pop_vld  = vld_q;
  assign pop_dat  = vld_q ? mem[rd_ptr] : '0;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on accept, queues {ctrl, pc, illegal} in order; 1 cycle to out_valid.
// in_ready is registered and low while the queue is full, even if execute pops that cycle.
module decode_stage
  import decoder_pkg::*;
#(
  parameter int INST_W   = 16,
  parameter int I_ADDR_W = 12,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 2,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_W-1:0]   in_instruction,
  input  logic [I_ADDR_W-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output decoded_ctrl_t       out_ctrl,
  output logic [I_ADDR_W-1:0] out_pc,
  output logic                out_illegal,
  output logic [CNT_W-1:0]    illegal_count
);

  if (DATA_W != DATA_IMM_W || INST_W < 16) begin : g_param_check
    $error("decode_stage: DATA_W must equal DATA_IMM_W and INST_W must be at least 16");
  end

  typedef struct packed {
    decoded_ctrl_t       ctrl;
    logic [I_ADDR_W-1:0] pc;
    logic                illegal;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  decode_result_t   dec;
  entry_t           push_entry;
  entry_t           head;
  logic             accept;
  logic [CNT_W-1:0] illegal_cnt_q;

  assign dec        = decode_inst(in_instruction[15:0]);
  assign push_entry = '{ctrl: dec.ctrl, pc: in_pc, illegal: dec.illegal};
  assign accept     = in_valid & in_ready & ~flush;

  decode_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (push_entry),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt_q <= '0;
    end else if (accept && dec.illegal && illegal_cnt_q != '1) begin
      illegal_cnt_q <= illegal_cnt_q + CNT_ONE;
    end
  end

  assign out_ctrl      = head.ctrl;
  assign out_pc        = head.pc;
  assign out_illegal   = head.illegal;
  assign illegal_count = illegal_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, backpressure/flush/reset sequences, random scoreboard run.
module tb_decode_stage;
  import decoder_pkg::*;

  localparam int INST_W   = 16;
  localparam int I_ADDR_W = 12;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 2;
  localparam int CNT_W    = 2;
  localparam int NVEC     = 18;

  logic                clk;
  logic                rst;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [INST_W-1:0]   in_instruction;
  logic [I_ADDR_W-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  decoded_ctrl_t       out_ctrl;
  logic [I_ADDR_W-1:0] out_pc;
  logic                out_illegal;
  logic [CNT_W-1:0]    illegal_count;

  decode_stage #(
    .INST_W(INST_W), .I_ADDR_W(I_ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_pc(out_pc),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    decoded_ctrl_t       ctrl;
    logic [I_ADDR_W-1:0] pc;
    logic                illegal;
  } exp_t;

  typedef struct {
    logic [15:0]         instr;
    logic [I_ADDR_W-1:0] pc;
    decoded_ctrl_t       ctrl;
    logic                illegal;
    int                  cnt;
  } vec_t;

  exp_t                q[$];
  logic [I_ADDR_W-1:0] popped[$];
  vec_t                tbl[NVEC];
  int                  vectors = 0;
  int                  miscompares = 0;
  int                  mcnt = 0;
  bit                  chk_en = 0;
  bit                  last_push;
  bit                  last_pop;

  // Reference decoder: classify the word into an instruction kind, then list what that kind drives.
  function automatic exp_t ref_decode(input logic [15:0] w, input logic [I_ADDR_W-1:0] pc);
    exp_t e;
    string kind;
    e.ctrl = '0;
    e.pc = pc;
    e.illegal = 1'b0;
    if (w[0]) kind = "BR";
    else if (w[3:1] == 3'd0) kind = "ALUI";
    else if (w[3:1] == 3'd1) kind = "ALUR";
    else if (w[3:1] == 3'd2 && w[7:4] == 4'd0) kind = "LOAD";
    else if (w[3:1] == 3'd2 && w[7:4] == 4'd1) kind = "STORE";
    else if (w[3:1] == 3'd2 && w[7:4] == 4'd2) kind = "GET";
    else if (w[3:1] == 3'd2 && w[7:4] == 4'd3) kind = "PUT";
    else if (w[3:1] == 3'd2 && w[7:4] == 4'd4) kind = "SET";
    else if (w[3:1] == 3'd4) kind = "JMPI";
    else if (w[3:1] == 3'd7 && w[7:4] == 4'd0) kind = "JMPR";
    else if (w[3:1] == 3'd7 && w[7:4] == 4'd1) kind = "JMP";
    else kind = "ILL";
    if (kind == "BR" || kind == "JMPI" || kind == "JMPR" || kind == "JMP") e.ctrl.jump_branch_select = 1'b1;
    if (kind == "BR" || kind == "JMPI") begin
      e.ctrl.immediate_address_select = 1'b1;
      e.ctrl.address_immediate = w[15:4];
    end
    if (kind == "BR") e.ctrl.branch_condition = w[3:1];
    if (kind == "JMPI" || kind == "JMPR" || kind == "JMP") e.ctrl.unconditional_branch = 1'b1;
    if (kind == "JMPR") e.ctrl.jump_relative = 1'b1;
    if (kind == "ALUI" || kind == "ALUR") begin
      e.ctrl.alu_function = w[6:4];
      e.ctrl.alu_output_enable = 1'b1;
      e.ctrl.status_write_enable = 1'b1;
    end
    if (kind == "ALUI") e.ctrl.alu_operand_b_immediate = w[15:8];
    if (kind == "ALUR") e.ctrl.read_data_output_enable = 1'b1;
    if (kind == "ALUI" || kind == "ALUR" || kind == "LOAD" || kind == "GET" || kind == "SET")
      e.ctrl.acc_write_enable = 1'b1;
    if (kind == "ALUR" || kind == "GET" || kind == "PUT") e.ctrl.reg_addr = w[11:8];
    if (kind == "LOAD") e.ctrl.data_memory_output_enable = 1'b1;
    if (kind == "STORE") e.ctrl.data_memory_write_enable = 1'b1;
    if (kind == "GET") e.ctrl.read_get_acc = 1'b1;
    if (kind == "PUT") e.ctrl.write_put_acc = 1'b1;
    if (kind == "SET") e.ctrl.acc_immediate = w[15:8];
    if (kind == "ILL") e.illegal = 1'b1;
    return e;
  endfunction

  function automatic logic [11:0] sel_bits(input decoded_ctrl_t c);
    return {c.jump_branch_select, c.immediate_address_select, c.unconditional_branch, c.jump_relative,
            c.alu_output_enable, c.status_write_enable, c.acc_write_enable, c.read_data_output_enable,
            c.read_get_acc, c.write_put_acc, c.data_memory_output_enable, c.data_memory_write_enable};
  endfunction

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Immediates of an illegal instruction are don't-care, so only enables/selects are checked there.
  task automatic chk_head(input string tag, input decoded_ctrl_t c, input logic [I_ADDR_W-1:0] pc,
                          input logic ill);
    check1({tag, ".out_valid"}, 64'(out_valid), 64'(1));
    check1({tag, ".out_pc"}, 64'(out_pc), 64'(pc));
    check1({tag, ".out_illegal"}, 64'(out_illegal), 64'(ill));
    if (ill) check1({tag, ".ctrl_sel"}, 64'(sel_bits(out_ctrl)), 64'(0));
    else check1({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(c));
  endtask

  task automatic check_reset_vals(input string tag);
    check1({tag, ".out_valid"}, 64'(out_valid), 64'(0));
    check1({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    check1({tag, ".illegal_count"}, 64'(illegal_count), 64'(0));
    check1({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(0));
    check1({tag, ".out_pc"}, 64'(out_pc), 64'(0));
    check1({tag, ".out_illegal"}, 64'(out_illegal), 64'(0));
  endtask

  // One clock: check DUT against the scoreboard at negedge, advance the model at posedge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (chk_en) begin
      check1("sb.in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      check1("sb.out_valid", 64'(out_valid), 64'(q.size() != 0));
      check1("sb.illegal_count", 64'(illegal_count), 64'(mcnt));
      if (q.size() != 0 && out_valid) chk_head("sb.head", q[0].ctrl, q[0].pc, q[0].illegal);
    end
    last_push = in_valid && (q.size() < DEPTH) && !flush && !rst;
    last_pop  = out_ready && (q.size() != 0) && !rst;
    if (last_pop) popped.push_back(out_pc);
    @(posedge clk);
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (last_pop) void'(q.pop_front());
      if (flush) q.delete();
      else if (last_push) begin
        e = ref_decode(in_instruction[15:0], in_pc);
        q.push_back(e);
        if (e.illegal && mcnt < (1 << CNT_W) - 1) mcnt++;
      end
    end
    #1;
  endtask

  task automatic put(input int i, input logic [15:0] w, input logic [I_ADDR_W-1:0] pc,
                     input decoded_ctrl_t c, input logic ill, input int cnt);
    tbl[i].instr = w; tbl[i].pc = pc; tbl[i].ctrl = c; tbl[i].illegal = ill; tbl[i].cnt = cnt;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_vals(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    decoded_ctrl_t c;
    int k, n, acc, cycles;
    bit did_rst;

    c = '0; c.alu_output_enable = 1'b1; c.acc_write_enable = 1'b1; c.status_write_enable = 1'b1;
    c.alu_operand_b_immediate = 8'h55;                                      put(0, 16'h5500, 12'h010, c, 1'b0, 0);
    c = '0; c.jump_branch_select = 1'b1; c.immediate_address_select = 1'b1;
    c.address_immediate = 12'h200;                                          put(1, 16'h2001, 12'h020, c, 1'b0, 0);
    c = '0; c.jump_branch_select = 1'b1; c.unconditional_branch = 1'b1; c.jump_relative = 1'b1;
                                                                            put(2, 16'h000E, 12'h030, c, 1'b0, 0);
    c = '0; c.jump_branch_select = 1'b1; c.unconditional_branch = 1'b1;    put(3, 16'h001E, 12'h031, c, 1'b0, 0);
    c = '0;                                                                 put(4, 16'h0006, 12'h040, c, 1'b1, 1);
                                                                            put(5, 16'h000A, 12'h041, c, 1'b1, 2);
                                                                            put(6, 16'h000C, 12'h042, c, 1'b1, 3);
    c = '0; c.alu_function = 3'd1; c.alu_output_enable = 1'b1; c.acc_write_enable = 1'b1;
    c.status_write_enable = 1'b1; c.read_data_output_enable = 1'b1; c.reg_addr = 4'hA;
                                                                            put(7, 16'h3A12, 12'h050, c, 1'b0, 3);
    c = '0; c.data_memory_output_enable = 1'b1; c.acc_write_enable = 1'b1; put(8, 16'h0004, 12'h051, c, 1'b0, 3);
    c = '0; c.data_memory_write_enable = 1'b1;                              put(9, 16'h0014, 12'h052, c, 1'b0, 3);
    c = '0; c.read_get_acc = 1'b1; c.acc_write_enable = 1'b1; c.reg_addr = 4'h5;
                                                                            put(10, 16'h0524, 12'h053, c, 1'b0, 3);
    c = '0; c.write_put_acc = 1'b1; c.reg_addr = 4'h7;                     put(11, 16'h0734, 12'h054, c, 1'b0, 3);
    c = '0; c.acc_write_enable = 1'b1; c.acc_immediate = 8'h99;            put(12, 16'h9944, 12'h055, c, 1'b0, 3);
    c = '0;                                                                 put(13, 16'h0054, 12'h056, c, 1'b1, 3);
    c = '0; c.jump_branch_select = 1'b1; c.immediate_address_select = 1'b1; c.unconditional_branch = 1'b1;
    c.address_immediate = 12'hABC;                                          put(14, 16'hABC8, 12'h057, c, 1'b0, 3);
    c = '0;                                                                 put(15, 16'h002E, 12'h058, c, 1'b1, 3);
    c = '0; c.jump_branch_select = 1'b1; c.immediate_address_select = 1'b1; c.branch_condition = 3'b101;
    c.address_immediate = 12'h7F5;                                          put(16, 16'h7F5B, 12'h059, c, 1'b0, 3);
    c = '0; c.alu_function = 3'd7; c.alu_output_enable = 1'b1; c.acc_write_enable = 1'b1;
    c.status_write_enable = 1'b1; c.alu_operand_b_immediate = 8'hF0;       put(17, 16'hF0F0, 12'h05A, c, 1'b0, 3);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instruction = '0; in_pc = '0;
    cyc();
    cyc();
    rst = 1'b0;
    chk_en = 1;
    check_reset_vals("reset");

    // Back-to-back table: each row shows up exactly one cycle after it is accepted.
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      in_valid = 1'b1;
      in_instruction = tbl[i].instr;
      in_pc = tbl[i].pc;
      cyc();
      chk_head($sformatf("tbl%0d", i), tbl[i].ctrl, tbl[i].pc, tbl[i].illegal);
      check1($sformatf("tbl%0d.illegal_count", i), 64'(illegal_count), 64'(tbl[i].cnt));
    end
    in_valid = 1'b0;
    cyc();

    // Backpressure: three offers into a two-entry queue with execute stalled.
    popped.delete();
    out_ready = 1'b0;
    k = 0;
    n = 0;
    while (k < 3 && n < 20) begin
      in_valid = 1'b1;
      in_instruction = {4'(k + 1), 4'(k + 1), 8'h00};
      in_pc = 12'(12'h100 + k);
      if (n == 4) out_ready = 1'b1;
      cyc();
      if (last_push) begin
        k++;
        if (k == 2) check1("bp.full_in_ready", 64'(in_ready), 64'(0));
      end
      n++;
    end
    check1("bp.accepts", 64'(k), 64'(3));
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (popped.size() < 3 && n < 10) begin
      cyc();
      n++;
    end
    check1("bp.pop_count", 64'(popped.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < popped.size()) check1($sformatf("bp.order%0d", i), 64'(popped[i]), 64'(12'h100 + i));
    end

    // Mid-stream reset with a partially full queue.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instruction = 16'h000C;
    in_pc = 12'h0C0;
    cyc();
    in_valid = 1'b1;
    do_reset("midreset");

    // Flush while full, offering an illegal instruction that must be dropped and not counted.
    in_instruction = 16'h1100;
    k = 0;
    n = 0;
    while (k < 2 && n < 10) begin
      in_pc = 12'(12'h200 + k);
      cyc();
      if (last_push) k++;
      n++;
    end
    check1("fl.filled", 64'(k), 64'(2));
    popped.delete();
    flush = 1'b1;
    out_ready = 1'b1;
    in_instruction = 16'h0006;
    in_pc = 12'h3FF;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    check1("fl.out_valid", 64'(out_valid), 64'(0));
    check1("fl.in_ready", 64'(in_ready), 64'(1));
    check1("fl.illegal_count", 64'(illegal_count), 64'(0));
    repeat (4) cyc();
    check1("fl.pops", 64'(popped.size()), 64'(1));

    // Random traffic against the scoreboard, with one reset partway through.
    acc = 0;
    cycles = 0;
    did_rst = 0;
    while (acc < 1000 && cycles < 20000) begin
      rst = (!did_rst && acc >= 500);
      if (rst) did_rst = 1;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 63) == 0);
      in_instruction = 16'($urandom);
      in_pc = 12'($urandom);
      cyc();
      if (last_push) acc++;
      cycles++;
      if (rst) begin
        rst = 1'b0;
        check_reset_vals("rand.reset");
      end
    end
    check1("rand.accepts", 64'(acc), 64'(1000));
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    check1("rand.drained", 64'(out_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
